// File: rtl/multislope_seq_pkg.sv
// Shared definitions for the multi-slope converter sequencer.
// FSM state encodings and comparator polarity.
package multislope_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_RUNUP   = 3'd2,
    S_RUNDOWN = 3'd3,
    S_ZERO    = 3'd4
  } state_t;

  // cmp low means the integrator has reached zero
  localparam logic CMP_AT_ZERO  = 1'b0;
  localparam logic CMP_NOT_ZERO = 1'b1;

endpackage

// File: rtl/multislope_seq_sync2.sv
// 2-flop synchroniser for the integrator comparator.
// Ports: clk1ms, rst (async active-low), d (async in), q (synced out).
module multislope_seq_sync2
  import multislope_seq_pkg::*;
(
  input  logic clk1ms,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // resets to not-at-zero so a fresh rundown never ends early
  always_ff @(posedge clk1ms or negedge rst) begin
    if (!rst) begin
      meta <= CMP_NOT_ZERO;
      q    <= CMP_NOT_ZERO;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/multislope_seq.sv
// Multi-slope converter phase sequencer: start, run-up, rundown, zero.
// In: clk1ms rst npl enable single cmp. Out: start runup rundown zero
// done busy rd_count nsub timeout (all registered).
module multislope_seq
  import multislope_seq_pkg::*;
#(
  parameter int NPL_W    = 10,
  parameter int SUB_LEN  = 20,
  parameter int ZERO_LEN = 5,
  parameter int RD_MAX   = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk1ms,
  input  logic             rst,
  input  logic [NPL_W-1:0] npl,
  input  logic             enable,
  input  logic             single,
  input  logic             cmp,
  output logic             start,
  output logic             runup,
  output logic             rundown,
  output logic             zero,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] rd_count,
  output logic [NPL_W-1:0] nsub,
  output logic             timeout
);

  localparam int SUB_W = $clog2(SUB_LEN + 1);
  localparam int ZC_W  = $clog2(ZERO_LEN + 1);

  if ((RD_MAX >> CNT_W) != 0) begin : g_bad_rdmax
    $error("RD_MAX does not fit in CNT_W bits");
  end

  state_t           state, state_n;
  logic [NPL_W-1:0] npl_q;
  logic [SUB_W-1:0] sub;
  logic [ZC_W-1:0]  zc;
  logic             cmp_s;

  logic sub_last, run_last;
  logic cmp_hit, rd_max, zc_last;

  multislope_seq_sync2 u_sync (
    .clk1ms (clk1ms),
    .rst    (rst),
    .d      (cmp),
    .q      (cmp_s)
  );

  assign sub_last = sub == SUB_W'(SUB_LEN - 1);
  assign run_last = sub_last &&
                    (nsub == npl_q - NPL_W'(1));
  assign cmp_hit  = cmp_s == CMP_AT_ZERO;
  assign rd_max   = rd_count == CNT_W'(RD_MAX);
  assign zc_last  = zc == ZC_W'(ZERO_LEN - 1);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (enable | single) state_n = S_START;
      S_START:
        state_n = (npl_q != '0) ? S_RUNUP
                                : S_RUNDOWN;
      S_RUNUP:
        if (run_last) state_n = S_RUNDOWN;
      S_RUNDOWN:
        if (cmp_hit | rd_max) state_n = S_ZERO;
      S_ZERO:
        if (zc_last) state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  // outputs are registered copies of the next-state decode
  always_ff @(posedge clk1ms or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      npl_q    <= '0;
      sub      <= '0;
      zc       <= '0;
      start    <= 1'b0;
      runup    <= 1'b0;
      rundown  <= 1'b0;
      zero     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      rd_count <= '0;
      nsub     <= '0;
      timeout  <= 1'b0;
    end else begin
      state   <= state_n;
      start   <= state_n == S_START;
      runup   <= state_n == S_RUNUP;
      rundown <= state_n == S_RUNDOWN;
      zero    <= state_n == S_ZERO;
      busy    <= state_n != S_IDLE;
      done    <= (state == S_ZERO) &&
                 (state_n == S_IDLE);

      if (state != S_RUNDOWN &&
          state_n == S_RUNDOWN)
        rd_count <= CNT_W'(1);

      unique case (state)
        S_IDLE: begin
          if (state_n == S_START) begin
            npl_q    <= npl;
            sub      <= '0;
            nsub     <= '0;
            rd_count <= '0;
            timeout  <= 1'b0;
          end
        end
        S_START: begin
          sub <= '0;
        end
        S_RUNUP: begin
          if (sub_last) begin
            sub  <= '0;
            nsub <= nsub + NPL_W'(1);
          end else begin
            sub <= sub + SUB_W'(1);
          end
        end
        S_RUNDOWN: begin
          if (state_n == S_ZERO) begin
            // a simultaneous cmp hit is not a timeout
            timeout <= rd_max & ~cmp_hit;
            zc      <= '0;
          end else begin
            rd_count <= rd_count + CNT_W'(1);
          end
        end
        S_ZERO: begin
          zc <= zc + ZC_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multislope_seq.sv
// Self-checking bench for multislope_seq.
// Conversions are checked against phase lengths from plain arithmetic.
module tb_multislope_seq;

  localparam int SUBL  = 20;
  localparam int ZLEN  = 5;
  localparam int RDMAX = 255;
  localparam int STUCK = 100000;

  logic        clk1ms = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  npl = '0;
  logic        enable = 1'b0;
  logic        single = 1'b0;
  logic        cmp = 1'b1;
  logic        start, runup, rundown, zero;
  logic        done, busy, timeout;
  logic [15:0] rd_count;
  logic [9:0]  nsub;

  int errors = 0;
  int checks = 0;

  multislope_seq dut (
    .clk1ms   (clk1ms),
    .rst      (rst),
    .npl      (npl),
    .enable   (enable),
    .single   (single),
    .cmp      (cmp),
    .start    (start),
    .runup    (runup),
    .rundown  (rundown),
    .zero     (zero),
    .done     (done),
    .busy     (busy),
    .rd_count (rd_count),
    .nsub     (nsub),
    .timeout  (timeout)
  );

  always #5 clk1ms = ~clk1ms;

  task automatic check(input string tag,
                       input longint obs,
                       input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // f = rundown cycle at whose start cmp falls
  // (0 = already low); synchroniser adds 2 cycles
  function automatic int exp_rd(input int f);
    if (f == 0) return 1;
    return (f + 2 > RDMAX) ? RDMAX : f + 2;
  endfunction

  function automatic int exp_to(input int f);
    return (f != 0 && f + 2 > RDMAX) ? 1 : 0;
  endfunction

  function automatic logic [32:0] all_out();
    return {start, runup, rundown, zero, done,
            busy, timeout, rd_count, nsub};
  endfunction

  task automatic run_conv(input string tag,
                          input bit    trig,
                          input int    n,
                          input int    f,
                          input int    lead,
                          input int    n_mid,
                          input bit    drop_en,
                          input bit    mid_single);
    int c_st = 0, c_ru = 0, c_rd = 0, c_z = 0;
    int c_done = 0, bad = 0, pre = 0;
    int ph = 0, last_ph = 0, guard = 0;
    bit prev_z = 0, fin = 0;
    cmp = (f == 0) ? 1'b0 : 1'b1;
    if (trig) begin
      npl = n[9:0];
      single = 1'b1;
    end
    while (!fin && guard < 3000) begin
      @(negedge clk1ms);
      guard++;
      single = 1'b0;
      ph = start ? 1 : runup ? 2 :
           rundown ? 3 : zero ? 4 : 0;
      c_st += int'(start);
      c_ru += int'(runup);
      c_rd += int'(rundown);
      c_z  += int'(zero);
      if (int'(start) + int'(runup) +
          int'(rundown) + int'(zero) > 1) bad++;
      if (ph != 0 && !busy) bad++;
      if (ph != 0) begin
        if (ph < last_ph) bad++;
        last_ph = ph;
      end
      if (c_st == 0 && ph == 0) pre++;
      if (done) begin
        c_done++;
        if (!prev_z || busy) bad++;
        fin = 1;
      end
      prev_z = zero;
      if (rundown && c_rd == f) cmp = 1'b0;
      if (runup && c_ru == 5) begin
        if (n_mid >= 0) npl = n_mid[9:0];
        if (drop_en) enable = 1'b0;
        if (mid_single) single = 1'b1;
      end
    end
    check({tag, ".lead"}, longint'(pre <= lead), 1);
    check({tag, ".done"}, c_done, 1);
    check({tag, ".start"}, c_st, 1);
    check({tag, ".runup"}, c_ru, n * SUBL);
    check({tag, ".rundown"}, c_rd, exp_rd(f));
    check({tag, ".zero"}, c_z, ZLEN);
    check({tag, ".seq"}, bad, 0);
    check({tag, ".nsub"}, nsub, n);
    check({tag, ".rd_count"}, rd_count, exp_rd(f));
    check({tag, ".timeout"}, timeout, exp_to(f));
  endtask

  task automatic idle_check(input string tag,
                            input int k);
    int act = 0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk1ms);
      act += int'(busy | start | done);
    end
    check(tag, act, 0);
  endtask

  initial begin
    int n, f, sel, cnt;
    repeat (3) @(negedge clk1ms);
    check("reset_outs", all_out(), 0);
    rst = 1'b1;
    idle_check("idle_after_reset", 4);

    run_conv("t1", 1, 3, 8, 0, -1, 0, 0);
    run_conv("t2", 1, 2, 10, 0, -1, 0, 1);
    idle_check("single_dropped", 6);
    run_conv("t3", 1, 1, STUCK, 0, -1, 0, 0);
    run_conv("t3b", 1, 1, 253, 0, -1, 0, 0);
    run_conv("t3c", 1, 0, 254, 0, -1, 0, 0);
    run_conv("t4", 1, 0, 0, 0, -1, 0, 0);

    npl = 10'd3;
    enable = 1'b1;
    run_conv("t5a", 0, 3, 5, 0, 1, 0, 0);
    run_conv("t5b", 0, 1, 12, 0, 4, 0, 0);
    run_conv("t5c", 0, 4, 0, 0, -1, 1, 0);
    idle_check("enable_dropped", 6);

    npl = 10'd3;
    single = 1'b1;
    cmp = 1'b1;
    @(negedge clk1ms);
    single = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 25; i++) begin
      @(negedge clk1ms);
      cnt += int'(runup);
    end
    check("reached_runup25", cnt, 25);
    rst = 1'b0;
    #1;
    check("mid_reset_outs", all_out(), 0);
    @(negedge clk1ms);
    check("reset_hold_outs", all_out(), 0);
    npl = 10'd2;
    enable = 1'b1;
    rst = 1'b1;
    run_conv("t6", 0, 2, 7, 2, -1, 0, 0);
    run_conv("t6b", 0, 2, 3, 0, -1, 1, 0);
    idle_check("t6_idle", 4);

    for (int i = 0; i < 6; i++) begin
      n = int'($urandom_range(0, 5));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: f = 0;
        1: f = int'($urandom_range(1, 40));
        2: f = int'($urandom_range(250, 256));
        default: f = STUCK;
      endcase
      run_conv($sformatf("rnd%0d", i),
               1, n, f, 0, -1, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
